// File: rtl/adder_slice_sched_if.sv
// rtl/adder_slice_sched_if.sv - request/result handshake bundle for the shared slice adder
interface adder_slice_sched_if #(
  parameter int WIDTH = 12
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_cin;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_cin;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;
  logic             res_id;
  logic             busy;

  // producer/consumer side
  modport master (
    output req0_valid, req0_a, req0_b, req0_cin,
    output req1_valid, req1_a, req1_b, req1_cin,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_sum, res_cout, res_id, busy
  );

  // adder side
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin,
    input  req1_valid, req1_a, req1_b, req1_cin,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_sum, res_cout, res_id, busy
  );
endinterface

// File: rtl/adder_slice_sched.sv
// rtl/adder_slice_sched.sv - two-requester round-robin serial adder built on one narrow slice
module adder_slice_sched #(
  parameter int WIDTH = 12,
  parameter int SLICE = 3
) (
  input logic               clk,
  input logic               rst_n,
  adder_slice_sched_if.slave bus
);
  localparam int NSL = WIDTH / SLICE;
  localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NSL - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic             id_q;
  logic             valid_q;
  logic             last_grant;
  logic [IW-1:0]    idx;

  logic             gnt0;
  logic             gnt1;
  logic [SLICE-1:0] sl_a;
  logic [SLICE-1:0] sl_b;
  logic [SLICE:0]   sl_sum;

  // Round-robin grant: a lone requester always wins, a tie goes to whoever was not served last
  assign gnt0 = (state == IDLE) && bus.req0_valid && (!bus.req1_valid || last_grant);
  assign gnt1 = (state == IDLE) && bus.req1_valid && (!bus.req0_valid || !last_grant);

  // The one shared slice: current operand fields plus the chained carry
  assign sl_a   = op_a[idx*SLICE +: SLICE];
  assign sl_b   = op_b[idx*SLICE +: SLICE];
  assign sl_sum = {1'b0, sl_a} + {1'b0, sl_b} + {{SLICE{1'b0}}, carry_q};

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.res_valid  = valid_q;
  assign bus.res_sum    = sum_q;
  assign bus.res_cout   = cout_q;
  assign bus.res_id     = id_q;
  assign bus.busy       = (state != IDLE);

  // Sequencer: accept one operand pair, run NSL slice cycles, hold the result until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_a       <= '0;
      op_b       <= '0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      cout_q     <= 1'b0;
      id_q       <= 1'b0;
      valid_q    <= 1'b0;
      last_grant <= 1'b1;
      idx        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt0) begin
            op_a       <= bus.req0_a;
            op_b       <= bus.req0_b;
            carry_q    <= bus.req0_cin;
            idx        <= '0;
            id_q       <= 1'b0;
            last_grant <= 1'b0;
            state      <= RUN;
          end else if (gnt1) begin
            op_a       <= bus.req1_a;
            op_b       <= bus.req1_b;
            carry_q    <= bus.req1_cin;
            idx        <= '0;
            id_q       <= 1'b1;
            last_grant <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          sum_q[idx*SLICE +: SLICE] <= sl_sum[SLICE-1:0];
          carry_q                   <= sl_sum[SLICE];
          idx                       <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            cout_q  <= sl_sum[SLICE];
            valid_q <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          // the result handshake only frees the adder; a new grant waits for IDLE
          if (bus.res_ready) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_slice_sched.sv
// tb/tb_adder_slice_sched.sv - directed and randomized checks for adder_slice_sched
module tb_adder_slice_sched;
  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  adder_slice_sched_if #(.WIDTH(12)) bus ();

  adder_slice_sched #(.WIDTH(12), .SLICE(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          req;
    logic [11:0] a;
    logic [11:0] b;
    logic        cin;
    logic [11:0] exp_sum;
    logic        exp_cout;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_req(input bit r, input logic v, input logic [11:0] a,
                         input logic [11:0] b, input logic c);
    if (!r) begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_cin = c;
    end else begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_cin = c;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic sel_ready(input bit r);
    return r ? bus.req1_ready : bus.req0_ready;
  endfunction

  // One directed operation; the other requester is kept valid during RUN/DONE to prove it is ignored
  task automatic run_vec(input vec_t v, input string nm);
    int w;
    int lat;
    @(negedge clk);
    set_req(v.req, 1'b1, v.a, v.b, v.cin);
    #1;
    w = 0;
    while (!sel_ready(v.req) && w < 20) begin
      @(negedge clk); #1; w++;
    end
    chk({nm, "_grant"}, {31'd0, sel_ready(v.req)}, 32'd1);
    chk({nm, "_other_ready"}, {31'd0, sel_ready(!v.req)}, 32'd0);
    @(posedge clk); #1;
    set_req(v.req, 1'b0, 12'h000, 12'h000, 1'b0);
    set_req(!v.req, 1'b1, 12'hABC, 12'h123, 1'b1);
    lat = 0;
    while (lat < 20) begin
      chk({nm, "_readies_busy"}, {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
      @(posedge clk); #1; lat++;
      if (bus.res_valid) break;
    end
    chk({nm, "_latency"}, lat, 32'd4);
    chk({nm, "_sum"}, {20'd0, bus.res_sum}, {20'd0, v.exp_sum});
    chk({nm, "_cout"}, {31'd0, bus.res_cout}, {31'd0, v.exp_cout});
    chk({nm, "_id"}, {31'd0, bus.res_id}, {31'd0, v.req});
    chk({nm, "_busy_done"}, {31'd0, bus.busy}, 32'd1);
    set_req(!v.req, 1'b0, 12'h000, 12'h000, 1'b0);
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    chk({nm, "_valid_fall"}, {31'd0, bus.res_valid}, 32'd0);
    chk({nm, "_busy_idle"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          grants;
    int          results;
    int          cyc;
    int          done;
    bit          exp_q[$];
    logic [13:0] sb[$];
    logic [13:0] e;
    logic [11:0] stall_sum;
    logic        any_valid;

    vecs[0] = '{1'b0, 12'hFFF, 12'h001, 1'b0, 12'h000, 1'b1};
    vecs[1] = '{1'b1, 12'h555, 12'h2AA, 1'b1, 12'h800, 1'b0};
    vecs[2] = '{1'b0, 12'h000, 12'h000, 1'b0, 12'h000, 1'b0};
    vecs[3] = '{1'b1, 12'hFFF, 12'hFFF, 1'b1, 12'hFFF, 1'b1};
    vecs[4] = '{1'b0, 12'h123, 12'h456, 1'b0, 12'h579, 1'b0};
    vecs[5] = '{1'b1, 12'h800, 12'h800, 1'b0, 12'h000, 1'b1};
    vecs[6] = '{1'b0, 12'hABC, 12'h544, 1'b1, 12'h001, 1'b1};
    vecs[7] = '{1'b1, 12'h7FF, 12'h000, 1'b1, 12'h800, 1'b0};

    rst_n = 1'b1;
    bus.res_ready = 1'b0;
    set_req(1'b0, 1'b0, 12'h000, 12'h000, 1'b0);
    set_req(1'b1, 1'b0, 12'h000, 12'h000, 1'b0);
    #2 rst_n = 1'b0;
    @(negedge clk); #1;
    chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("rst_res_sum", {20'd0, bus.res_sum}, 32'd0);
    chk("rst_res_cout", {31'd0, bus.res_cout}, 32'd0);
    chk("rst_res_id", {31'd0, bus.res_id}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_readies", {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Both requesters valid from reset: grants must alternate starting with requester 0
    do_reset();
    @(negedge clk);
    set_req(1'b0, 1'b1, 12'h100, 12'h0FF, 1'b1);
    set_req(1'b1, 1'b1, 12'hF00, 12'h200, 1'b0);
    bus.res_ready = 1'b1;
    grants = 0; results = 0; cyc = 0;
    while (results < 4 && cyc < 200) begin
      #1;
      if (bus.req0_ready && bus.req1_ready) chk("rr_dual_grant", 32'd1, 32'd0);
      if (bus.req0_ready || bus.req1_ready) begin
        chk($sformatf("rr_grant%0d", grants), {31'd0, bus.req1_ready}, grants % 2);
        exp_q.push_back(bus.req1_ready);
        grants++;
      end
      if (bus.res_valid) begin
        chk($sformatf("rr_id%0d", results), {31'd0, bus.res_id}, {31'd0, exp_q[results]});
        chk($sformatf("rr_sum%0d", results), {19'd0, bus.res_cout, bus.res_sum},
            bus.res_id ? 32'h1100 : 32'h0200);
        results++;
      end
      @(negedge clk); cyc++;
    end
    chk("rr_results", results, 32'd4);
    set_req(1'b0, 1'b0, 12'h000, 12'h000, 1'b0);
    set_req(1'b1, 1'b0, 12'h000, 12'h000, 1'b0);
    bus.res_ready = 1'b0;

    // Result stalled for 6 cycles with both requesters pushing
    do_reset();
    @(negedge clk);
    set_req(1'b0, 1'b1, 12'h0F0, 12'h00F, 1'b1);
    set_req(1'b1, 1'b1, 12'hFFF, 12'h001, 1'b1);
    cyc = 0;
    while (!bus.res_valid && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    chk("stall_valid", {31'd0, bus.res_valid}, 32'd1);
    stall_sum = bus.res_sum;
    chk("stall_first_sum", {20'd0, stall_sum}, 32'h100);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("stall_hold", {13'd0, bus.res_valid, bus.busy, bus.req0_ready, bus.req1_ready,
                         bus.res_id, bus.res_cout, bus.res_sum},
          {13'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h100});
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    chk("stall_release_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("stall_next_grant", {30'd0, bus.req0_ready, bus.req1_ready}, 32'd1);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 12'h000, 12'h000, 1'b0);
    set_req(1'b1, 1'b0, 12'h000, 12'h000, 1'b0);
    cyc = 0;
    while (!bus.res_valid && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    chk("stall_next_result", {18'd0, bus.res_valid, bus.res_id, bus.res_cout, bus.res_sum},
        {18'd0, 1'b1, 1'b1, 1'b1, 12'h001});
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;

    // Reset two cycles into RUN aborts the operation immediately
    @(negedge clk);
    set_req(1'b0, 1'b1, 12'h123, 12'h111, 1'b0);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 12'h000, 12'h000, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    chk("abort_partial_busy", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {16'd0, bus.res_valid, bus.busy, bus.res_id, bus.res_cout, bus.res_sum},
        32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    any_valid = 1'b0;
    repeat (8) begin @(posedge clk); #1; any_valid |= bus.res_valid; end
    chk("abort_no_result", {31'd0, any_valid}, 32'd0);
    run_vec(vecs[4], "after_abort");

    // Random traffic with stalls, scoreboarded in issue order
    done = 0; cyc = 0;
    while (done < 1000 && cyc < 30000) begin
      @(negedge clk); cyc++;
      set_req(1'b0, $urandom_range(0, 3) != 0, 12'($urandom), 12'($urandom), 1'($urandom));
      set_req(1'b1, $urandom_range(0, 3) != 0, 12'($urandom), 12'($urandom), 1'($urandom));
      bus.res_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (bus.req0_valid && bus.req0_ready)
        sb.push_back({1'b0, {1'b0, bus.req0_a} + {1'b0, bus.req0_b} + {12'd0, bus.req0_cin}});
      if (bus.req1_valid && bus.req1_ready)
        sb.push_back({1'b1, {1'b0, bus.req1_a} + {1'b0, bus.req1_b} + {12'd0, bus.req1_cin}});
      if (bus.res_valid && bus.res_ready) begin
        if (sb.size() == 0) begin
          chk("rand_unexpected_result", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("rand_result", {18'd0, bus.res_id, bus.res_cout, bus.res_sum}, {18'd0, e});
        end
        done++;
      end
    end
    chk("rand_count", done, 32'd1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
